// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// State literals carry an S_ prefix so they never collide with module parameters.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_POP     = 3'd1,
        S_CAPTURE = 3'd2,
        S_START   = 3'd3,
        S_DATA    = 3'd4,
        S_PARITY  = 3'd5,
        S_STOP    = 3'd6
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic read_clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge read_clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

    assign bit_tick = (r_count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO read port and serializes them as UART frames.
// tx is registered from the next-state decode so the line changes exactly on state boundaries.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       read_clk,
    input  logic       rst,
    input  logic       tx_enable,
    input  logic       mem_empty,
    input  logic [7:0] read_data,
    output logic       read_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output tx_state_e  state
);

    localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    tx_state_e  r_state;
    tx_state_e  w_next;
    logic [7:0] r_shift;
    logic [7:0] w_shift_next;
    logic [2:0] r_bit_cnt;
    logic       r_stop_cnt;
    logic       r_par;
    logic       w_par_next;
    logic       r_tx;
    logic       w_tx_next;
    logic       w_tick;
    logic       w_clear;
    logic       w_last_stop;

    assign w_clear = (r_state == S_IDLE) || (r_state == S_CAPTURE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .read_clk (read_clk),
        .rst      (rst),
        .clear    (w_clear),
        .bit_tick (w_tick)
    );

    always_comb begin
        w_next       = r_state;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_last_stop  = (r_stop_cnt == LAST_STOP);
        case (r_state)
            S_IDLE:    if (tx_enable && !mem_empty) w_next = S_POP;
            S_POP:     w_next = S_CAPTURE;
            S_CAPTURE: begin
                w_shift_next = read_data;
                w_par_next   = 1'b0;
                w_next       = S_START;
            end
            S_START:   if (w_tick) w_next = S_DATA;
            S_DATA: begin
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    w_par_next   = r_par ^ r_shift[0];
                    if (r_bit_cnt == 3'd7) begin
                        w_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY:  if (w_tick) w_next = S_STOP;
            S_STOP:    if (w_tick && w_last_stop) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase

        // The parity accumulator already includes bit 7 when PARITY is entered.
        w_tx_next = IDLE_LEVEL;
        case (w_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = (PARITY == PAR_ODD) ? ~w_par_next : w_par_next;
            default:  w_tx_next = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= IDLE_LEVEL;
        end else begin
            r_state <= w_next;
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_tx    <= w_tx_next;

            if (r_state != S_DATA && w_next == S_DATA) begin
                r_bit_cnt <= '0;
            end else if (r_state == S_DATA && w_tick) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (r_state != S_STOP && w_next == S_STOP) begin
                r_stop_cnt <= 1'b0;
            end else if (r_state == S_STOP && w_tick) begin
                r_stop_cnt <= ~r_stop_cnt;
            end
        end
    end

    assign read_en = (r_state == S_POP);
    assign busy    = (r_state != S_IDLE);
    assign tx_done = (r_state == S_STOP) && w_tick && w_last_stop;
    assign tx      = r_tx;
    assign state   = r_state;

endmodule
